trace_frame_scheduler: RTL
==========================

// Module: trace_frame_scheduler
// PURPOSE
// - Takes completed 128-bit TPIU frames from the trace-clock front end (toggle indicator FrAvail + Frame bus)
//   into the system clock domain and buffers them in a small FIFO.
// - Schedules one shared 128-bit output link between buffered trace frames and periodic status packets.
// - Sits between the trace input stage and the packet processor; keeps frame/loss statistics.
// PARAMETERS
// - DEPTH_LOG2   3     log2 of FIFO depth in frames (default 8 frames)
// - SYNC_STAGES  2     synchroniser flops on FrAvail (>=2)
// - HB_PERIOD    2**20 clk cycles between status packets (>=4)
// PORTS
// - clk          in   1    system clock; all logic on its rising edge
// - rst          in   1    reset, synchronous to clk, active-high
// - FrAvail      in   1    toggles once per completed frame; asynchronous to clk
// - Frame        in   128  frame data; stable >= SYNC_STAGES+3 clk cycles after each FrAvail toggle
// - width        in   2    current trace bus width code; reported in status
// - clrStats     in   1    one-cycle pulse: clear counters and overflow flag
// - DataReady    in   1    downstream accepts Data this cycle
// - DataVal      out  1    Data valid
// - Data         out  128  frame or status packet
// - DataIsStatus out  1    1 = Data is a status packet
// - overflow     out  1    sticky: at least one frame was dropped
// - frameCount   out  16   frames enqueued; wraps at 2**16
// - lostCount    out  16   frames dropped; saturates at 16'hFFFF
// BEHAVIOUR
// - Reset: all outputs 0; FIFO empty; state IDLE; heartbeat counter 0; edge detector disarmed.
// - Edge detect: FrAvail passes through SYNC_STAGES flops, then a 'last' register. The first cycle after
//   reset, 'last' loads the synchronised value and arms. No capture occurs while disarmed, so a high
//   FrAvail at reset release is not a frame.
// - Capture: synced != last while armed -> Frame is written to the FIFO that cycle.
//   Latency from toggle to write: SYNC_STAGES+1 cycles.
// - Full FIFO on capture: frame dropped, lostCount +1 (saturating), overflow <= 1.
//   Write on the same cycle as a read with the FIFO full is accepted (pop frees the slot first).
// - Heartbeat counter: counts 0..HB_PERIOD-1, then wraps and sets statusPending.
//   It is cleared when the status packet is accepted. A second wrap while still pending is merged.
// - FSM IDLE / SEND_FRAME / SEND_STATUS. The output register is loaded only in IDLE, or in the cycle
//   the current word is accepted.
//   - Decision rule: statusPending wins, else the FIFO head if not empty, else IDLE with DataVal=0.
//   - Back-to-back transfers run at 1 word/clk. First word appears 1 cycle after the FIFO write.
// - Handshake: the transfer completes when DataVal & DataReady. While DataVal & !DataReady,
//   Data and DataIsStatus stay constant. DataVal never drops without acceptance.
// - Status layout: [127:112]=16'hA5A5, [111:96]=frameCount, [95:80]=lostCount,
//   [79:64]={13'b0,overflow,width}, [63:0]=0. Values are sampled when the word is loaded.
// - clrStats: zeroes frameCount, lostCount and overflow. It beats a same-cycle increment, so that event
//   is not counted. FIFO contents and the pending status are unaffected.
// - rst mid-transfer: FIFO flushed and DataVal=0 next cycle. Queued frames are lost and not counted.
// CONFIGURATION
// - TRACE_HEARTBEAT_EN defined: heartbeat counter and status packets present as above.
// - Not defined: no counter, statusPending is constant 0, SEND_STATUS unreachable, DataIsStatus tied 0.
//   HB_PERIOD is ignored.
// STRUCTURE
// - Shared package trace_pkg: STATUS_MARKER=16'hA5A5, status field offsets, FSM state enum, FRAME_W=128.
// - Sub-module trace_toggle_sync: synchroniser chain, arm logic, one-cycle capture pulse.
// - FIFO is inline: register array plus DEPTH_LOG2+1-bit read/write pointers; the MSB distinguishes full from empty.
// TESTING
// - Frame=128'h00112233_44556677_8899AABB_CCDDEEFF, FrAvail 0->1, DataReady=1 -> DataVal high for exactly
//   1 cycle, SYNC_STAGES+2 cycles after the toggle. Data equals Frame, DataIsStatus=0, frameCount=1.
// - DataReady=0, DEPTH_LOG2=3, 9 toggles -> lostCount=1, overflow=1. With DataReady=1, frames 1..8 emerge
//   in order and frame 9 never appears.
// - HB_PERIOD=16, TRACE_HEARTBEAT_EN defined, no frames -> status every 16 cycles with
//   Data[127:112]=16'hA5A5 and Data[65:64]=width.
// - 3 frames queued, heartbeat wraps while frame 1 is presented -> output order is frame1, status, frame2, frame3.
//   Data is unchanged during random DataReady stalls.
// - rst asserted with 3 frames queued and FrAvail held 1 through release -> DataVal=0 and all counts 0 next cycle;
//   no frame is output until FrAvail toggles.
// - clrStats on the same cycle as a dropped frame -> lostCount=0 and overflow=0 on the following cycle.

Source files
------------

// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared constants, status word layout and FSM state type for the trace scheduler
package trace_pkg;

   localparam int FRAME_W = 128;
   localparam logic [15:0] STATUS_MARKER = 16'hA5A5;

   localparam int ST_MARKER_LSB = 112;
   localparam int ST_FRAMES_LSB = 96;
   localparam int ST_LOST_LSB   = 80;
   localparam int ST_FLAGS_LSB  = 64;

   typedef enum logic [1:0] {
      IDLE,
      SEND_FRAME,
      SEND_STATUS
   } schedState_e;

   function automatic logic [FRAME_W-1:0] buildStatus(input logic [15:0] frames,
                                                      input logic [15:0] lost,
                                                      input logic        ovf,
                                                      input logic [1:0]  busWidth);
      logic [FRAME_W-1:0] word;
      word = '0;
      word[ST_MARKER_LSB +: 16] = STATUS_MARKER;
      word[ST_FRAMES_LSB +: 16] = frames;
      word[ST_LOST_LSB +: 16]   = lost;
      word[ST_FLAGS_LSB +: 3]   = {ovf, busWidth};
      return word;
   endfunction

endpackage

// File: rtl/trace_toggle_sync.sv
// rtl/trace_toggle_sync.sv - synchronises the FrAvail toggle into clk and emits a one-cycle capture pulse
module trace_toggle_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic toggleIn,
   output logic capture
);

   logic [SYNC_STAGES-1:0] syncChain;
   logic                   synced;
   logic                   lastSynced;
   logic                   armed;

   if (SYNC_STAGES < 2) begin : gSyncCheck
      $error("SYNC_STAGES must be at least 2");
   end

   // The chain keeps sampling through reset so a level held across release is already settled.
   always_ff @(posedge clk) begin
      syncChain <= {syncChain[SYNC_STAGES-2:0], toggleIn};
   end

   assign synced = syncChain[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         lastSynced <= 1'b0;
         armed      <= 1'b0;
      end else begin
         lastSynced <= synced;
         armed      <= 1'b1;
      end
   end

   assign capture = armed & (synced ^ lastSynced);

endmodule

// File: rtl/trace_frame_scheduler.sv
// rtl/trace_frame_scheduler.sv - buffers trace frames and shares the output link with status packets (TRACE_HEARTBEAT_EN)
module trace_frame_scheduler
   import trace_pkg::*;
#(
   parameter int DEPTH_LOG2  = 3,
   parameter int SYNC_STAGES = 2,
   parameter int HB_PERIOD   = 2**20
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               FrAvail,
   input  logic [FRAME_W-1:0] Frame,
   input  logic [1:0]         width,
   input  logic               clrStats,
   input  logic               DataReady,
   output logic               DataVal,
   output logic [FRAME_W-1:0] Data,
   output logic               DataIsStatus,
   output logic               overflow,
   output logic [15:0]        frameCount,
   output logic [15:0]        lostCount
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int PW    = DEPTH_LOG2 + 1;

   logic [FRAME_W-1:0] fifoMem [DEPTH];
   logic [PW-1:0]      wrPtr, rdPtr, candPtr;
   logic               capture, full, pop, wrEn, drop, load, candEmpty;
   logic               statusPending, statusAccept;
   logic [FRAME_W-1:0] statusWord, dataNext;
   schedState_e        state, stateNext;

   if (HB_PERIOD < 4) begin : gHbCheck
      $error("HB_PERIOD must be at least 4");
   end

   trace_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) uSync (
      .clk      (clk),
      .rst      (rst),
      .toggleIn (FrAvail),
      .capture  (capture)
   );

   // The presented frame stays at the FIFO head until accepted, so it still occupies a slot.
   assign full         = (wrPtr - rdPtr) == PW'(DEPTH);
   assign pop          = (state == SEND_FRAME) && DataReady;
   assign statusAccept = (state == SEND_STATUS) && DataReady;
   assign wrEn         = capture && (!full || pop);
   assign drop         = capture && full && !pop;
   assign load         = (state == IDLE) || pop || statusAccept;
   assign candPtr      = rdPtr + PW'(pop);
   assign candEmpty    = (candPtr == wrPtr);
   assign statusWord   = buildStatus(frameCount, lostCount, overflow, width);
   assign DataVal      = (state != IDLE);

   always_comb begin
      stateNext = state;
      dataNext  = Data;
      if (load) begin
         if (statusPending && !statusAccept) begin
            stateNext = SEND_STATUS;
            dataNext  = statusWord;
         end else if (!candEmpty) begin
            stateNext = SEND_FRAME;
            dataNext  = fifoMem[candPtr[PW-2:0]];
         end else begin
            stateNext = IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wrEn) begin
         fifoMem[wrPtr[PW-2:0]] <= Frame;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         Data       <= '0;
         wrPtr      <= '0;
         rdPtr      <= '0;
         frameCount <= '0;
         lostCount  <= '0;
         overflow   <= 1'b0;
      end else begin
         state <= stateNext;
         Data  <= dataNext;
         if (wrEn) wrPtr <= wrPtr + 1'b1;
         if (pop)  rdPtr <= rdPtr + 1'b1;
         // A clear in the same cycle as an event wins and the event goes uncounted.
         if (clrStats) begin
            frameCount <= '0;
            lostCount  <= '0;
            overflow   <= 1'b0;
         end else begin
            if (wrEn) frameCount <= frameCount + 16'd1;
            if (drop) begin
               overflow <= 1'b1;
               if (lostCount != 16'hFFFF) lostCount <= lostCount + 16'd1;
            end
         end
      end
   end

`ifdef TRACE_HEARTBEAT_EN
   localparam int HB_W = $clog2(HB_PERIOD);

   logic [HB_W-1:0] hbCount;
   logic            hbWrap;

   assign hbWrap = (hbCount == HB_W'(HB_PERIOD - 1));

   // A wrap while a status is still pending merges into that one packet.
   always_ff @(posedge clk) begin
      if (rst) begin
         hbCount       <= '0;
         statusPending <= 1'b0;
      end else begin
         hbCount <= hbWrap ? '0 : hbCount + 1'b1;
         if (hbWrap) begin
            statusPending <= 1'b1;
         end else if (statusAccept) begin
            statusPending <= 1'b0;
         end
      end
   end

   assign DataIsStatus = (state == SEND_STATUS);
`else
   assign statusPending = 1'b0;
   assign DataIsStatus  = 1'b0;
`endif

endmodule
